discus_seq: RTL
===============

DISCUS_SEQ -- requirements
Module: discus_seq

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program counter and program memory address width (8..16).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning number of return-stack entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning reset: synchronous, active-low.
REQ-005 SHALL have ports prog_we (input, 1), prog_addr (input, PC_W) and prog_data (input, 8), meaning the program memory write port.
REQ-006 SHALL have ports z_flag, c_flag and z_pending (inputs, 1 each), meaning the flags from the execute unit; z_pending means a Z update is in flight.
REQ-007 SHALL have port stall, input, 1, meaning hold all sequencer state this cycle.
REQ-008 SHALL have ports instr_out (output, 8), instr_valid (output, 1), const_out (output, PC_W) and pc_out (output, PC_W), meaning the issued instruction, its qualifier, the accumulated prefix and the instruction address plus 1.
REQ-009 SHALL have port stack_err, output, 2, meaning sticky flags: bit0 overflow, bit1 underflow.

Function
REQ-010 SHALL hold 2^PC_W x 8 program RAM with a registered read; a write and a read to the same address in one cycle return the old data.
REQ-011 SHALL be a two-stage pipeline (fetch, decode); the instruction at address P reaches decode 2 cycles after P is issued.
REQ-012 SHALL decode 00dddddd as a prefix: prefix <= {prefix, d} truncated to PC_W; instr_valid=0.
REQ-013 SHALL decode 01xxxxxx and 11xxxxxx as plain instructions: instr_valid=1, const_out=prefix; prefix then clears to 0.
REQ-014 SHALL decode 10 oo ccc x as control: oo=00 JUMP, 01 CALL, 10 RET, 11 NOP; instr_valid=0; prefix clears.
REQ-015 SHALL evaluate conditions as follows: ccc=000 always, 001 never, 010 Z, 011 !Z, 100 C, 101 !C, 11x always.
REQ-016 SHALL set the JUMP/CALL target to prefix and the RET target to the top of the stack.
REQ-017 SHALL, on a taken branch, squash the instruction in fetch (one bubble) and fetch the target on the next cycle.
REQ-018 SHALL, on a taken CALL, push decode address+1 and increment SP; on a taken RET, decrement SP; SP wraps modulo STACK_DEPTH.
REQ-019 SHALL, when a Z/!Z condition meets z_pending=1, hold decode and fetch until z_pending=0 and then evaluate.
REQ-020 SHALL, with stall=1, freeze PC, SP, prefix, stack and all outputs; prog_we still writes.
REQ-021 SHALL treat a CALL with the stack full as an overwrite of the oldest entry (circular), and a RET with the stack empty as a return to the wrapped entry.

Reset
REQ-022 SHALL, while reset_n=0 at a clock edge, set PC=0, SP=0, depth=0, prefix=0, instr_valid=0, instr_out=0, const_out=0, pc_out=0 and stack_err=0; stack contents are undefined.
REQ-023 SHALL, after reset_n rises, fetch address 0 at the first edge, squashing any in-flight instruction including a pending branch.

Configuration
REQ-024 SHALL, with DISCUS_STACK_CHECK_EN defined, track occupancy (0..STACK_DEPTH) and set stack_err[0] on a CALL when full and stack_err[1] on a RET when empty; flags stay set until reset.
REQ-025 SHALL, without DISCUS_STACK_CHECK_EN, omit occupancy logic and tie stack_err to 0; wrap behaviour is unchanged.

Structure
REQ-026 SHALL take opcode field constants, condition codes and the control-op enumeration from shared package discus_pkg.
REQ-027 SHALL implement the return stack as sub-module discus_stack (params STACK_DEPTH, PC_W; push, pop, top, full, empty).

Verification
REQ-028 SHALL cover: load 0x40,0x41,0x42 at 0..2, release reset -> instr_valid pulses with 0x40,0x41,0x42 on cycles 2,3,4, pc_out 1,2,3.
REQ-029 SHALL cover: program 0x03,0x05,0x80 (JUMP always) -> next valid fetch from 0xC5 (PC_W=8), exactly one bubble.
REQ-030 SHALL cover: CALL to 0x10, RET at 0x10 -> execution resumes at the CALL address+1; SP returns to 0.
REQ-031 SHALL cover: z_pending=1 for 3 cycles with JUMP-if-Z and z_flag=1 -> decode held 3 cycles, then the branch is taken.
REQ-032 SHALL cover: 5 nested CALLs with STACK_DEPTH=4 and the macro defined -> stack_err=01; a RET at depth 0 -> stack_err=11; reset_n=0 -> 00.
REQ-033 SHALL cover: reset_n=0 during a taken branch -> the next issued instruction is from address 0.

Source files
------------

// File: rtl/discus_pkg.sv
// Shared opcode fields, condition codes and control-op encoding for the
// discus sequencer and its return stack.
package discus_pkg;

    localparam logic [1:0] OPC_PREFIX = 2'b00;
    localparam logic [1:0] OPC_CTRL   = 2'b10;

    typedef enum logic [1:0] {
        CTL_JUMP = 2'b00,
        CTL_CALL = 2'b01,
        CTL_RET  = 2'b10,
        CTL_NOP  = 2'b11
    } ctrl_op_e;

    localparam logic [2:0] CC_ALWAYS = 3'b000;
    localparam logic [2:0] CC_NEVER  = 3'b001;
    localparam logic [2:0] CC_Z      = 3'b010;
    localparam logic [2:0] CC_NZ     = 3'b011;
    localparam logic [2:0] CC_C      = 3'b100;
    localparam logic [2:0] CC_NC     = 3'b101;

    function automatic logic cond_met(input logic [2:0] ccc, input logic z, input logic c);
        logic r;
        case (ccc)
            CC_ALWAYS: r = 1'b1;
            CC_NEVER:  r = 1'b0;
            CC_Z:      r = z;
            CC_NZ:     r = ~z;
            CC_C:      r = c;
            CC_NC:     r = ~c;
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic cond_uses_z(input logic [2:0] ccc);
        return (ccc == CC_Z) || (ccc == CC_NZ);
    endfunction

endpackage

// File: rtl/discus_stack.sv
// Circular return stack. With DISCUS_STACK_CHECK_EN defined it also tracks
// occupancy to report full/empty; otherwise full and empty are tied low.
module discus_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0] mem_r [STACK_DEPTH];
    logic [SP_W-1:0] sp_r;
    logic [SP_W-1:0] sp_dec_s;

    assign sp_dec_s = sp_r - SP_W'(1);
    assign top      = mem_r[sp_dec_s];

    // Stack pointer wraps freely; a push on a full stack overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp_r <= '0;
        end else if (push) begin
            sp_r <= sp_r + SP_W'(1);
        end else if (pop) begin
            sp_r <= sp_dec_s;
        end else begin
            sp_r <= sp_r;
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[sp_r] <= push_data;
        end
    end

`ifdef DISCUS_STACK_CHECK_EN
    logic [SP_W:0] depth_r;

    // Occupancy saturates at both ends so it keeps meaning after wrap
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_r <= '0;
        end else if (push && (depth_r != (SP_W+1)'(STACK_DEPTH))) begin
            depth_r <= depth_r + (SP_W+1)'(1);
        end else if (pop && (depth_r != '0)) begin
            depth_r <= depth_r - (SP_W+1)'(1);
        end else begin
            depth_r <= depth_r;
        end
    end

    assign full  = (depth_r == (SP_W+1)'(STACK_DEPTH));
    assign empty = (depth_r == '0);
`else
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

endmodule

// File: rtl/discus_seq.sv
// Two-stage (fetch, decode) instruction sequencer with prefix constants and a
// return stack. Define DISCUS_STACK_CHECK_EN to enable stack_err reporting.
module discus_seq
    import discus_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [7:0]      prog_data,
    input  logic            z_flag,
    input  logic            c_flag,
    input  logic            z_pending,
    input  logic            stall,
    output logic [7:0]      instr_out,
    output logic            instr_valid,
    output logic [PC_W-1:0] const_out,
    output logic [PC_W-1:0] pc_out,
    output logic [1:0]      stack_err
);

    logic [7:0]      pmem_r [2**PC_W];
    logic [7:0]      fetch_data_r;
    logic [PC_W-1:0] fetch_addr_r;
    logic            fetch_valid_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] prefix_r;

    logic [1:0]      opc_s;
    ctrl_op_e        op_s;
    logic [2:0]      ccc_s;
    logic            is_prefix_s;
    logic            is_ctrl_s;
    logic            is_plain_s;
    logic            z_hold_s;
    logic            advance_s;
    logic            taken_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [PC_W-1:0] top_s;
    logic [PC_W-1:0] target_s;
    logic [PC_W-1:0] pc_next_s;
    logic [PC_W-1:0] prefix_next_s;
    logic [PC_W-1:0] ret_addr_s;
    logic [1:0]      err_set_s;

    assign ret_addr_s = fetch_addr_r + PC_W'(1);

    // Decode of the fetched word; a Z-conditioned control op waits out z_pending
    always_comb begin
        opc_s       = fetch_data_r[7:6];
        op_s        = ctrl_op_e'(fetch_data_r[5:4]);
        ccc_s       = fetch_data_r[3:1];
        is_prefix_s = fetch_valid_r && (opc_s == OPC_PREFIX);
        is_ctrl_s   = fetch_valid_r && (opc_s == OPC_CTRL);
        is_plain_s  = fetch_valid_r && (opc_s != OPC_PREFIX) && (opc_s != OPC_CTRL);
        z_hold_s    = is_ctrl_s && cond_uses_z(ccc_s) && z_pending;
        advance_s   = !stall && !z_hold_s;
        taken_s     = is_ctrl_s && !z_hold_s && (op_s != CTL_NOP) &&
                      cond_met(ccc_s, z_flag, c_flag);
        push_s      = advance_s && taken_s && (op_s == CTL_CALL);
        pop_s       = advance_s && taken_s && (op_s == CTL_RET);
        target_s    = (op_s == CTL_RET) ? top_s : prefix_r;
        pc_next_s   = taken_s ? target_s : (pc_r + PC_W'(1));
        err_set_s   = {pop_s && empty_s, push_s && full_s};
        if (is_prefix_s) begin
            prefix_next_s = PC_W'({prefix_r, fetch_data_r[5:0]});
        end else if (fetch_valid_r) begin
            prefix_next_s = '0;
        end else begin
            prefix_next_s = prefix_r;
        end
    end

    // Program RAM write port stays live through stall and Z hold
    always_ff @(posedge clk) begin
        if (prog_we) begin
            pmem_r[prog_addr] <= prog_data;
        end
    end

    // Fetch stage: registered read; a taken branch squashes the word read alongside it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r          <= '0;
            fetch_data_r  <= 8'h00;
            fetch_addr_r  <= '0;
            fetch_valid_r <= 1'b0;
        end else if (advance_s) begin
            pc_r          <= pc_next_s;
            fetch_data_r  <= pmem_r[pc_r];
            fetch_addr_r  <= pc_r;
            fetch_valid_r <= !taken_s;
        end else begin
            pc_r          <= pc_r;
            fetch_data_r  <= fetch_data_r;
            fetch_addr_r  <= fetch_addr_r;
            fetch_valid_r <= fetch_valid_r;
        end
    end

    // Decode stage state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prefix_r    <= '0;
            instr_valid <= 1'b0;
            instr_out   <= 8'h00;
            const_out   <= '0;
            pc_out      <= '0;
            stack_err   <= 2'b00;
        end else if (stall) begin
            prefix_r    <= prefix_r;
            instr_valid <= instr_valid;
            instr_out   <= instr_out;
            const_out   <= const_out;
            pc_out      <= pc_out;
            stack_err   <= stack_err;
        end else if (z_hold_s) begin
            prefix_r    <= prefix_r;
            instr_valid <= 1'b0;
            instr_out   <= instr_out;
            const_out   <= const_out;
            pc_out      <= pc_out;
            stack_err   <= stack_err;
        end else begin
            prefix_r    <= prefix_next_s;
            instr_valid <= is_plain_s;
            stack_err   <= stack_err | err_set_s;
            if (is_plain_s) begin
                instr_out <= fetch_data_r;
                const_out <= prefix_r;
                pc_out    <= ret_addr_s;
            end else begin
                instr_out <= instr_out;
                const_out <= const_out;
                pc_out    <= pc_out;
            end
        end
    end

    discus_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PC_W        (PC_W)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (ret_addr_s),
        .top       (top_s),
        .full      (full_s),
        .empty     (empty_s)
    );

endmodule
